// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer: holds one of 2**CTRL grants until gnt_done or the hold limit,
// re-arbitrating in the release cycle so contending grants run back-to-back with no bubble.
module rr_grant_sequencer #(
   parameter int CTRL     = 2,
   parameter int MAX_HOLD = 16,
   localparam int N       = 2**CTRL,
   localparam int CNT_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic             gnt_done,
   output logic             gnt_valid,
   output logic [CTRL-1:0]  gnt_idx,
   output logic             timeout,
   output logic [CNT_W-1:0] busy_cnt
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   localparam logic [CNT_W-1:0] LIM_VAL = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] SAT_VAL = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);

   state_t          r_state;
   logic [CTRL-1:0] r_ptr;

   logic            w_any_req;
   logic            w_limit;
   logic            w_release;
   logic [CTRL-1:0] w_next_ptr;
   logic [CTRL-1:0] w_sel_idle;
   logic [CTRL-1:0] w_sel_rel;

   // Scan descending so the requester closest to the start index wins.
   function automatic logic [CTRL-1:0] f_pick(input logic [N-1:0] req_v,
                                              input logic [CTRL-1:0] start);
      logic [CTRL-1:0] idx;
      f_pick = start;
      for (int k = N - 1; k >= 0; k--) begin
         idx = start + CTRL'(k);
         if (req_v[idx]) f_pick = idx;
      end
   endfunction

   assign w_any_req  = |req;
   assign w_limit    = (MAX_HOLD != 0) && (busy_cnt == LIM_VAL);
   assign w_release  = gnt_done | w_limit;
   assign w_next_ptr = gnt_idx + CTRL'(1);
   assign w_sel_idle = f_pick(req, r_ptr);
   assign w_sel_rel  = f_pick(req, w_next_ptr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         timeout   <= 1'b0;
         busy_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state   <= S_GRANT;
                  gnt_valid <= 1'b1;
                  gnt_idx   <= w_sel_idle;
                  busy_cnt  <= '0;
               end else begin
                  gnt_valid <= 1'b0;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_ptr    <= w_next_ptr;
                  // done wins over the limit when both land in the same cycle
                  timeout  <= w_limit & ~gnt_done;
                  busy_cnt <= '0;
                  if (w_any_req) begin
                     gnt_idx <= w_sel_rel;
                  end else begin
                     r_state   <= S_IDLE;
                     gnt_valid <= 1'b0;
                  end
               end else if (busy_cnt != SAT_VAL) begin
                  busy_cnt <= busy_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer: directed vector table, async-reset sequence, then random
// stimulus against a behavioural round-robin model.
module tb_rr_grant_sequencer;

   localparam int CTRL  = 2;
   localparam int N     = 4;
   localparam int MH    = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     req = '0;
   logic             gnt_done = 1'b0;
   logic             gnt_valid;
   logic [CTRL-1:0]  gnt_idx;
   logic             timeout;
   logic [CNT_W-1:0] busy_cnt;

   rr_grant_sequencer #(.CTRL(CTRL), .MAX_HOLD(MH)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .gnt_done (gnt_done),
      .gnt_valid(gnt_valid),
      .gnt_idx  (gnt_idx),
      .timeout  (timeout),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model state
   int m_valid, m_idx, m_ptr, m_cnt, m_to;

   typedef struct {
      bit       rst;
      bit [3:0] rq;
      bit       dn;
      int       ev;
      int       ei;
      int       et;
      int       ec;   // -1: busy_cnt not checked
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit [3:0] rq, bit dn, int ev, int ei, int et, int ec);
      vec_t v;
      v.rst = rst; v.rq = rq; v.dn = dn; v.ev = ev; v.ei = ei; v.et = et; v.ec = ec;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   function automatic int pick(input bit [3:0] r, input int p);
      for (int o = 0; o < N; o++)
         if (r[(p + o) % N]) return (p + o) % N;
      return -1;
   endfunction

   function automatic void model_reset();
      m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
   endfunction

   function automatic void model_step(input bit [3:0] r, input bit dn);
      int limit_hit;
      m_to = 0;
      if (m_valid == 0) begin
         if (r != 0) begin
            m_valid = 1; m_idx = pick(r, m_ptr); m_cnt = 0;
         end
      end else begin
         limit_hit = (MH != 0 && m_cnt == MH - 1) ? 1 : 0;
         if (dn || limit_hit != 0) begin
            m_to  = dn ? 0 : 1;
            m_ptr = (m_idx + 1) % N;
            m_cnt = 0;
            if (r != 0) m_idx = pick(r, m_ptr);
            else        m_valid = 0;
         end else begin
            m_cnt = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
         end
      end
   endfunction

   task automatic tick();
      model_step(req, gnt_done);
      @(posedge clk);
      #1;
      chk("gnt_valid", int'(gnt_valid), m_valid);
      chk("gnt_idx", int'(gnt_idx), m_idx);
      chk("timeout", int'(timeout), m_to);
      if (m_valid != 0) chk("busy_cnt", int'(busy_cnt), m_cnt);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #2;
      model_reset();
      chk("rst_valid", int'(gnt_valid), 0);
      chk("rst_idx", int'(gnt_idx), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_busy_cnt", int'(busy_cnt), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // single request, release to idle
      tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 2, 0, -1));
      // full contention, wrap 3 -> 0
      tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 1, 2, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 1, 3, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, -1));
      // ptr=1: grant 1, release to idle (ptr=2), then scan 2,3,0 picks 0
      tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 1, 0, -1));
      tbl.push_back(mk(0, 4'b0011, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, -1));
      // hold limit on idx 3, next grant wraps to 0, timeout pulses once
      tbl.push_back(mk(0, 4'b1000, 0, 1, 3, 0, 0));
      tbl.push_back(mk(0, 4'b1001, 0, 1, 3, 0, 1));
      tbl.push_back(mk(0, 4'b1001, 0, 1, 3, 0, 2));
      tbl.push_back(mk(0, 4'b1001, 0, 1, 3, 0, 3));
      tbl.push_back(mk(0, 4'b1001, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, -1));
      // done coincides with the limit: no timeout; req drop does not end grant
      tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, 1));
      tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, 2));
      tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, 3));
      tbl.push_back(mk(0, 4'b0100, 1, 1, 2, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 2, 0, 1));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 2, 0, -1));

      model_reset();
      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            apply_reset();
         end else begin
            req = tbl[i].rq;
            gnt_done = tbl[i].dn;
            tick();
         end
         chk($sformatf("vec%0d_valid", i), int'(gnt_valid), tbl[i].ev);
         chk($sformatf("vec%0d_idx", i), int'(gnt_idx), tbl[i].ei);
         chk($sformatf("vec%0d_timeout", i), int'(timeout), tbl[i].et);
         if (tbl[i].ec >= 0) chk($sformatf("vec%0d_busy", i), int'(busy_cnt), tbl[i].ec);
      end

      // async reset mid-grant; ptr is 3 here, so req=1010 afterwards tells a cleared ptr apart
      req = 4'b0010; gnt_done = 1'b0;
      tick();
      chk("pre_rst_idx", int'(gnt_idx), 1);
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("async_valid", int'(gnt_valid), 0);
      chk("async_idx", int'(gnt_idx), 0);
      chk("async_timeout", int'(timeout), 0);
      chk("async_busy", int'(busy_cnt), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      req = 4'b1010;
      tick();
      chk("post_rst_idx", int'(gnt_idx), 1);
      chk("post_rst_valid", int'(gnt_valid), 1);
      req = 4'b1000; gnt_done = 1'b1;
      tick();
      chk("post_rst_next", int'(gnt_idx), 3);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         gnt_done = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/rr_grant_sequencer.md
Name: rr_grant_sequencer

Overview:
Round-robin arbiter that sits directly upstream of the parameterised demux. It picks one of 2**CTRL requesters and holds that grant until the requester signals completion or a hold limit expires. Its outputs gnt_idx and gnt_valid drive the demux ctrl and inp directly, so the demux fans the grant out as a one-hot vector. Typical uses: shared write-back port, memory arbiter, cache fill slots.

Parameters:
CTRL, 2, index width; number of requesters N = 2**CTRL.
MAX_HOLD, 16, maximum cycles a grant may be held without gnt_done; 0 disables the limit.
CNT_W, $clog2(MAX_HOLD+1), width of the hold counter; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  N  request vector, bit i = requester i.
gnt_done  input  1  granted requester has finished; sampled only while gnt_valid=1.
gnt_valid  output  1  a grant is active; connects to demux inp.
gnt_idx  output  CTRL  index of the granted requester; connects to demux ctrl.
timeout  output  1  one-cycle pulse: the previous grant was revoked by the hold limit.
busy_cnt  output  CNT_W  cycles elapsed in the current grant.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on reset. All outputs are registered.
- Reset values: state=IDLE, gnt_valid=0, gnt_idx=0, ptr=0, timeout=0, busy_cnt=0. Reset asserted mid-grant drops gnt_valid immediately, without waiting for a clock edge.
- ptr (CTRL bits) is the highest-priority index. Selection = first i with req[i]=1, scanning ptr, ptr+1, ... with wrap modulo N.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req!=0, next edge: state=GRANT, gnt_valid=1, gnt_idx=selection, busy_cnt=0.
  - Latency from req rising to gnt_valid is exactly 1 cycle.
  - If req==0, stay in IDLE with gnt_valid=0. gnt_idx keeps its last value.
- GRANT:
  - gnt_idx is stable for the whole grant.
  - busy_cnt increments each cycle and saturates at MAX_HOLD.
  - req[gnt_idx] dropping does not end the grant; only gnt_done or timeout ends it.
- Release events in GRANT:
  - gnt_done=1: release.
  - gnt_done=0, MAX_HOLD!=0 and busy_cnt==MAX_HOLD-1: release, and timeout=1 on the next cycle.
  - gnt_done and the limit in the same cycle: treated as done, no timeout.
- On release:
  - ptr <= gnt_idx+1 mod N; N-1 wraps to 0.
  - Re-arbitration happens in the same cycle over the current req vector, using the new ptr. The just-released index therefore has lowest priority.
  - If any req is set: stay in GRANT, load the new gnt_idx, busy_cnt=0. gnt_valid stays 1, giving back-to-back grants with no bubble.
  - Otherwise: go to IDLE and gnt_valid=0 on the next edge.
- timeout is high for exactly one cycle, then returns to 0.
- A single requester that re-requests immediately is granted again back-to-back; fairness only orders contending requesters.
- gnt_done while gnt_valid=0 is ignored.
- When CTRL=1 (N=2), arbitration alternates strictly under continuous contention.

Test Plan:
1. Reset, then req=4'b0100 at cycle 0 -> cycle 1: gnt_valid=1, gnt_idx=2. Downstream demux out[2]=1, all other outputs 0.
2. req=4'b1111 held, gnt_done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,3,0 with gnt_valid continuously 1. Check wrap 3 -> 0.
3. Grant idx 1 with req=4'b0010, then req drops to 0 and gnt_done=1 -> next cycle gnt_valid=0, state IDLE, ptr=2. Then req=4'b0011 -> grant idx 0 (scan 2,3,0).
4. MAX_HOLD=4, grant idx 3, gnt_done never asserted -> release after busy_cnt reaches 3. timeout=1 for one cycle. Next grant goes to the lowest pending index after 3 (wraps to 0).
5. MAX_HOLD=4, gnt_done=1 in the same cycle busy_cnt=3 -> timeout stays 0, normal release.
6. Assert reset asynchronously mid-grant (between edges) -> gnt_valid, gnt_idx, timeout, busy_cnt go to 0 immediately. After deassert with req=4'b1000 -> grant idx 3 one cycle later, ptr having restarted from 0.
